cursor_stepper: RTL and testbench

//   Consumes the periodic enable tick from the rate divider and steps a paint cursor

---
 rtl/cursor_stepper.sv | 154 +++++++++++++++
 tb/tb_cursor_stepper.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cursor_stepper.sv
// cursor_stepper: steps a paint cursor once per tick and plots a BRUSH x BRUSH square.
// Define CURSOR_WRAP_EN to wrap the cursor at canvas edges instead of clamping.
module cursor_stepper #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int X_MAX  = 159,
    parameter int Y_MAX  = 119,
    parameter int X_INIT = 80,
    parameter int Y_INIT = 60,
    parameter int BRUSH  = 2
) (
    input  logic           clock,
    input  logic           resetN,
    input  logic           tick,
    input  logic           up,
    input  logic           down,
    input  logic           left,
    input  logic           right,
    input  logic           pen_down,
    input  logic [2:0]     colour_in,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           plot,
    output logic [X_W-1:0] plot_x,
    output logic [Y_W-1:0] plot_y,
    output logic [2:0]     plot_colour,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, MOVE, PAINT} state_t;

    localparam logic [X_W-1:0] XM     = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YM     = Y_W'(Y_MAX);
    localparam logic [X_W:0]   XM_W   = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]   YM_W   = (Y_W+1)'(Y_MAX);
    localparam logic [1:0]     B_LAST = 2'(BRUSH - 1);
`ifdef CURSOR_WRAP_EN
    localparam logic [X_W-1:0] X_UNDER = XM;
    localparam logic [X_W-1:0] X_OVER  = '0;
    localparam logic [Y_W-1:0] Y_UNDER = YM;
    localparam logic [Y_W-1:0] Y_OVER  = '0;
`else
    localparam logic [X_W-1:0] X_UNDER = '0;
    localparam logic [X_W-1:0] X_OVER  = XM;
    localparam logic [Y_W-1:0] Y_UNDER = '0;
    localparam logic [Y_W-1:0] Y_OVER  = YM;
`endif

    state_t         state_q;
    logic [X_W-1:0] x_q, x_d, px_q;
    logic [Y_W-1:0] y_q, y_d, py_q;
    logic           up_q, down_q, left_q, right_q, pen_q;
    logic [2:0]     col_q, pc_q;
    logic [1:0]     i_q, j_q;
    logic           last_q, plot_q, busy_q;
    logic [X_W:0]   sx;
    logic [Y_W:0]   sy;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (left_q && !right_q)
            x_d = (x_q == '0) ? X_UNDER : x_q - X_W'(1);
        else if (right_q && !left_q)
            x_d = (x_q == XM) ? X_OVER : x_q + X_W'(1);
        if (up_q && !down_q)
            y_d = (y_q == '0) ? Y_UNDER : y_q - Y_W'(1);
        else if (down_q && !up_q)
            y_d = (y_q == YM) ? Y_OVER : y_q + Y_W'(1);
    end

    // One bit wider than the canvas so an off-canvas brush pixel is never aliased
    assign sx = {1'b0, x_q} + {{(X_W-1){1'b0}}, i_q};
    assign sy = {1'b0, y_q} + {{(Y_W-1){1'b0}}, j_q};

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            x_q     <= X_W'(X_INIT);
            y_q     <= Y_W'(Y_INIT);
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            pen_q   <= 1'b0;
            col_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            last_q  <= 1'b0;
            plot_q  <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            pc_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        up_q    <= up;
                        down_q  <= down;
                        left_q  <= left;
                        right_q <= right;
                        pen_q   <= pen_down;
                        col_q   <= colour_in;
                        i_q     <= '0;
                        j_q     <= '0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= MOVE;
                    end
                end
                MOVE: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    if (pen_q) begin
                        state_q <= PAINT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                PAINT: begin
                    if (last_q) begin
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        plot_q <= (sx <= XM_W) && (sy <= YM_W);
                        px_q   <= sx[X_W-1:0];
                        py_q   <= sy[Y_W-1:0];
                        pc_q   <= col_q;
                        if (i_q == B_LAST) begin
                            i_q <= '0;
                            if (j_q == B_LAST)
                                last_q <= 1'b1;
                            else
                                j_q <= j_q + 2'd1;
                        end else begin
                            i_q <= i_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign plot        = plot_q;
    assign plot_x      = px_q;
    assign plot_y      = py_q;
    assign plot_colour = pc_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_cursor_stepper.sv
// tb_cursor_stepper: randomized steps against a canvas model; pixels go
// through a scoreboard queue drained by an independent plot monitor.
`timescale 1ns/1ps
module tb_cursor_stepper;
    localparam int XMAX = 159;
    localparam int YMAX = 119;
    localparam int B    = 2;

    logic       clock = 1'b0;
    logic       resetN;
    logic       tick, up, down, left, right, pen_down;
    logic [2:0] colour_in;
    logic [7:0] x, plot_x;
    logic [6:0] y, plot_y;
    logic       plot, busy;
    logic [2:0] plot_colour;

    int checks = 0;
    int errors = 0;
    int mx, my;
    logic [17:0] sb[$];

    cursor_stepper dut (
        .clock(clock), .resetN(resetN), .tick(tick),
        .up(up), .down(down), .left(left), .right(right),
        .pen_down(pen_down), .colour_in(colour_in),
        .x(x), .y(y), .plot(plot), .plot_x(plot_x),
        .plot_y(plot_y), .plot_colour(plot_colour), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int nxt(int v, bit dec, bit inc, int vmax);
        if (dec && !inc) begin
            if (v > 0) return v - 1;
`ifdef CURSOR_WRAP_EN
            return vmax;
`else
            return 0;
`endif
        end
        if (inc && !dec) begin
            if (v < vmax) return v + 1;
`ifdef CURSOR_WRAP_EN
            return 0;
`else
            return vmax;
`endif
        end
        return v;
    endfunction

    task automatic push_brush(input logic [2:0] c);
        for (int j = 0; j < B; j++)
            for (int i = 0; i < B; i++)
                if (mx + i <= XMAX && my + j <= YMAX)
                    sb.push_back({8'(mx + i), 7'(my + j), c});
    endtask

    task automatic junk_inputs();
        {up, down, left, right, pen_down} = 5'($urandom);
        colour_in = 3'($urandom);
    endtask

    // Starts at posedge+1 with the DUT idle; ends the same way.
    task automatic do_step(input bit u, input bit d, input bit l,
                           input bit r, input bit p,
                           input logic [2:0] c, input bit extra);
        int  n, exp_n;
        bit  first;
        {up, down, left, right, pen_down} = {u, d, l, r, p};
        colour_in = c;
        tick = 1'b1;
        mx = nxt(mx, l, r, XMAX);
        my = nxt(my, u, d, YMAX);
        if (p) push_brush(c);
        exp_n = p ? B * B + 2 : 1;
        @(posedge clock); #1;
        tick = 1'b0;
        chk("busy_after_tick", busy, 1);
        n = 1;
        first = 1'b1;
        while (busy && n < 64) begin
            if (n == exp_n || (n == 2 && extra)) begin
                junk_inputs();
                tick = 1'b1;
            end
            @(posedge clock); #1;
            tick = 1'b0;
            if (first) begin
                chk("x_after_step", x, mx);
                chk("y_after_step", y, my);
                first = 1'b0;
            end
            if (busy) n++;
        end
        chk("busy_cycles", n, exp_n);
        @(posedge clock); #1;
        chk("idle_after_busy", busy, 0);
        chk("x_hold", x, mx);
        chk("y_hold", y, my);
        chk("pixels_left", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clock);
            if (resetN === 1'b1 && plot === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_plot: got (%0d,%0d,%0d), required no plot",
                             plot_x, plot_y, plot_colour);
                end else begin
                    e = sb.pop_front();
                    if ({plot_x, plot_y, plot_colour} !== e) begin
                        errors++;
                        $display("FAIL pixel: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                                 plot_x, plot_y, plot_colour, e[17:10], e[9:3], e[2:0]);
                    end
                end
                chk("plot_implies_busy", busy, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b0;
        tick = 1'b0;
        {up, down, left, right, pen_down} = '0;
        colour_in = '0;
        mx = 80;
        my = 60;
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
        chk("rst_x", x, 80);
        chk("rst_y", y, 60);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_plot_x", plot_x, 0);
        chk("rst_plot_y", plot_y, 0);
        chk("rst_colour", plot_colour, 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            chk("idle_plot", plot, 0);
            chk("idle_busy", busy, 0);
        end

        do_step(0, 0, 0, 1, 0, 3'b000, 0);
        do_step(0, 0, 1, 0, 0, 3'b000, 0);
        do_step(0, 0, 0, 0, 1, 3'b100, 1);
        do_step(1, 1, 0, 0, 0, 3'b000, 0);
        do_step(1, 1, 1, 1, 1, 3'b011, 1);

        while (mx < XMAX) do_step(0, 0, 0, 1, 0, 3'b000, 0);
        do_step(0, 0, 0, 1, 1, 3'b101, 0);
        for (int k = 0; k < 62; k++) do_step(0, 1, 0, 1, 1, 3'($urandom), 0);
        for (int k = 0; k < 165; k++) do_step(1, 0, 1, 0, k[0], 3'($urandom), 0);

        for (int k = 0; k < 150; k++)
            do_step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 3'($urandom), 1'($urandom));

        do_step(0, 0, 1, 0, 0, 3'b000, 0);
        {up, down, left, right, pen_down} = 5'b00001;
        colour_in = 3'b010;
        tick = 1'b1;
        push_brush(3'b010);
        repeat (3) begin
            @(posedge clock); #1;
            tick = 1'b0;
        end
        #2 resetN = 1'b0;
        #1;
        chk("midrst_plot", plot, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_x", x, 80);
        chk("midrst_y", y, 60);
        sb.delete();
        mx = 80;
        my = 60;
        @(posedge clock); #1 resetN = 1'b1;
        do_step(1, 0, 0, 1, 1, 3'b110, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
